udp_rx: RTL and testbench
=========================

// Module: udp_rx
// PURPOSE
// Receive-side UDP de-encapsulator. Takes an IP-payload byte stream on AXI-Stream and parses
// the 8-byte UDP header into parallel fields. Presents the header on a valid/ready port and
// forwards the payload as AXI-Stream. Sits between the IP RX parser and the application RX path.
// PARAMETERS
// AXI_DATA_WIDTH  8  stream data width; only 8 is supported (elaboration $error otherwise)
// PORTS
// i_clk             in   1   clock; all logic on posedge
// i_reset           in   1   asynchronous reset, active-high
// s_axis_tdata      in   8   IP payload byte (UDP header followed by UDP payload)
// s_axis_tvalid     in   1   input beat valid
// s_axis_tlast      in   1   last byte of the IP payload
// s_axis_trdy       out  1   input ready
// m_udp_hdr_tvalid  out  1   parsed header valid
// m_udp_hdr_trdy    in   1   header consumer ready
// m_udp_src_port    out  16  source port
// m_udp_dst_port    out  16  destination port
// m_udp_length      out  16  UDP length field, as received
// m_udp_checksum    out  16  UDP checksum field, as received; not verified
// m_axis_tdata      out  8   payload byte
// m_axis_tvalid     out  1   payload beat valid
// m_axis_tlast      out  1   last payload byte
// m_axis_trdy       in   1   payload consumer ready
// o_hdr_err         out  1   1-cycle pulse: frame ended before 8 header bytes were received
// o_len_err         out  1   1-cycle pulse at payload tlast: byte count != m_udp_length-8
// BEHAVIOUR
// Reset: all outputs 0, header fields 0, byte counter 0, state HDR.
// Byte order on the wire: big-endian. First byte goes to src_port[15:8].
// Byte map: bytes 0-1 src, 2-3 dst, 4-5 length, 6-7 checksum. Each field shifts in on its byte.
// Handshake rule: a beat transfers only when valid&&ready. Valid never waits on ready.
// States and transitions:
//  HDR     s_axis_trdy=1. Each accepted byte increments hdr_cnt (0..7).
//          tlast with hdr_cnt<7 -> pulse o_hdr_err, hdr_cnt<=0, stay in HDR. No header is emitted.
//          Byte 7 accepted -> m_udp_hdr_tvalid<=1, go to HDR_OUT. Record zero_pl=tlast.
//  HDR_OUT s_axis_trdy=0. Header fields hold stable while tvalid=1.
//          On m_udp_hdr_trdy: tvalid<=0. If zero_pl -> go to HDR; if m_udp_length!=8, pulse o_len_err.
//          Otherwise -> go to PAYLOAD with pl_cnt<=0.
//  PAYLOAD one-stage registered pipe, 1-cycle latency, full throughput.
//          s_axis_trdy = !m_axis_tvalid || m_axis_trdy.
//          Accepted beat -> tdata/tlast registered and m_axis_tvalid<=1; pl_cnt++ (16-bit, saturating).
//          Accepted tlast -> s_axis_trdy<=0 until the output register drains.
//          When it drains: if pl_cnt != m_udp_length-8 (16-bit wrap subtract), pulse o_len_err; go to HDR.
// Ordering: a frame's header is always accepted before its first payload beat is presented.
//   The next frame's header bytes are not accepted until the previous payload tlast has been taken.
// Backpressure: m_axis_trdy=0 holds tdata/tlast/tvalid stable. No beat is dropped or duplicated.
// Errors: o_len_err is advisory only; the payload is forwarded unmodified. o_hdr_err and o_len_err never assert together.
// Reset mid-frame: the partial frame is discarded and outputs go low immediately.
//   After reset, the next accepted byte is treated as header byte 0. Upstream must be reset together with this block.
// STRUCTURE
// Package udp_pkg:
//   UDP_HDR_BYTES=8
//   typedef enum logic[1:0] {HDR, HDR_OUT, PAYLOAD} udp_rx_state_t
//   typedef struct packed udp_hdr_t {src_port, dst_port, length, checksum}
// Sub-module axis_pipe_reg (one-stage AXI-S register, tdata+tlast) implements the PAYLOAD path.
// FSM, hdr_cnt and pl_cnt live in udp_rx.
// TESTING
// 1. Frame 12 34 56 78 00 0C AB CD 01 02 03 04(tlast), all ready=1 -> hdr src=1234 dst=5678 len=000C
//    csum=ABCD; payload 01..04, tlast on 04, each 1 cycle after input; no error pulses.
// 2. Same frame, m_udp_hdr_trdy held 0 for 5 cycles -> s_axis_trdy=0 throughout, fields stable; payload intact afterwards.
// 3. Random m_axis_trdy toggling (50%) on a 64-byte payload with len=0x0048
//    -> output bytes match input exactly; tlast once; o_len_err=0.
// 4. Frame of 5 bytes with tlast on byte 4 -> o_hdr_err 1-cycle pulse; no header valid;
//    next well-formed frame parses correctly.
// 5. len=0x0010 but only 4 payload bytes -> o_len_err pulse after tlast drains.
//    8-byte frame with len=0x0008 -> header emitted, no payload beat, no error.
// 6. Assert i_reset during payload byte 2 -> all outputs 0 asynchronously;
//    after release, a fresh frame parses as in test 1.

Source files
------------

// File: rtl/udp_pkg.sv
// Shared types for the UDP receive path: parser states and the parsed 8-byte header.
package udp_pkg;

    localparam int UDP_HDR_BYTES = 8;

    typedef enum logic [1:0] {
        HDR,
        HDR_OUT,
        PAYLOAD
    } udp_rx_state_t;

    // Field order matches wire order, so byte 0 lands in the MSB of src_port.
    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [15:0] length;
        logic [15:0] checksum;
    } udp_hdr_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// One-stage AXI-Stream register for data+last; latency 1 cycle, full throughput.
// Backpressure: output holds while m_rdy=0; accepts input when empty or draining the same cycle.
module axis_pipe_reg #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] s_dat,
    input  logic         s_vld,
    input  logic         s_lst,
    output logic         s_rdy,
    output logic [W-1:0] m_dat,
    output logic         m_vld,
    output logic         m_lst,
    input  logic         m_rdy
);

    assign s_rdy = !m_vld || m_rdy;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            m_vld <= 1'b0;
            m_dat <= '0;
            m_lst <= 1'b0;
        end else if (s_rdy) begin
            m_vld <= s_vld;
            if (s_vld) begin
                m_dat <= s_dat;
                m_lst <= s_lst;
            end
        end
    end

endmodule

// File: rtl/udp_rx.sv
// UDP de-encapsulator: parses the 8-byte header onto a valid/ready port; payload 1-cycle registered.
// Backpressure: input stalls while the header waits for its consumer and while the payload register is full.
module udp_rx
    import udp_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 8
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [7:0]  s_axis_tdata,
    input  logic        s_axis_tvalid,
    input  logic        s_axis_tlast,
    output logic        s_axis_trdy,
    output logic        m_udp_hdr_tvalid,
    input  logic        m_udp_hdr_trdy,
    output logic [15:0] m_udp_src_port,
    output logic [15:0] m_udp_dst_port,
    output logic [15:0] m_udp_length,
    output logic [15:0] m_udp_checksum,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    output logic        m_axis_tlast,
    input  logic        m_axis_trdy,
    output logic        o_hdr_err,
    output logic        o_len_err
);

    if (AXI_DATA_WIDTH != 8) begin : g_width_check
        $error("udp_rx: only AXI_DATA_WIDTH = 8 is supported");
    end

    udp_rx_state_t state_q, state_d;
    udp_hdr_t      hdr_q;
    logic [2:0]    hdr_cnt_q;
    logic [15:0]   pl_cnt_q;
    logic [15:0]   pl_exp;
    logic          hdr_vld_q;
    logic          zero_pl_q;
    logic          last_in_q;
    logic          hdr_err_q;
    logic          len_err_q;
    logic          in_acc;
    logic          hdr_done;
    logic          hdr_short;
    logic          hdr_take;
    logic          pl_drain;
    logic          pipe_s_vld;
    logic          pipe_s_rdy;

    assign in_acc    = s_axis_tvalid && s_axis_trdy;
    assign hdr_done  = (state_q == HDR) && in_acc && (hdr_cnt_q == 3'(UDP_HDR_BYTES - 1));
    assign hdr_short = (state_q == HDR) && in_acc && s_axis_tlast && !hdr_done;
    assign hdr_take  = (state_q == HDR_OUT) && m_udp_hdr_trdy;
    // Frame is complete only once the buffered tlast beat has left the output register.
    assign pl_drain  = (state_q == PAYLOAD) && last_in_q && m_axis_tvalid && m_axis_trdy && m_axis_tlast;
    assign pl_exp    = hdr_q.length - 16'(UDP_HDR_BYTES);

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= HDR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HDR:     if (hdr_done) state_d = HDR_OUT;
            HDR_OUT: if (m_udp_hdr_trdy) state_d = zero_pl_q ? HDR : PAYLOAD;
            PAYLOAD: if (pl_drain) state_d = HDR;
            default: state_d = HDR;
        endcase
    end

    always_comb begin
        s_axis_trdy = 1'b0;
        pipe_s_vld  = 1'b0;
        case (state_q)
            HDR: s_axis_trdy = 1'b1;
            PAYLOAD: begin
                s_axis_trdy = !last_in_q && pipe_s_rdy;
                pipe_s_vld  = s_axis_tvalid && !last_in_q;
            end
            default: s_axis_trdy = 1'b0;
        endcase
        // Keep the input closed while reset is held so nothing is taken mid-reset.
        if (i_reset) begin
            s_axis_trdy = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            hdr_q     <= '0;
            hdr_cnt_q <= '0;
            pl_cnt_q  <= '0;
            hdr_vld_q <= 1'b0;
            zero_pl_q <= 1'b0;
            last_in_q <= 1'b0;
            hdr_err_q <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            hdr_err_q <= hdr_short;
            len_err_q <= (hdr_take && zero_pl_q && (hdr_q.length != 16'(UDP_HDR_BYTES)))
                      || (pl_drain && (pl_cnt_q != pl_exp));

            if ((state_q == HDR) && in_acc) begin
                hdr_cnt_q <= (s_axis_tlast || hdr_done) ? 3'd0 : hdr_cnt_q + 3'd1;
                case (hdr_cnt_q[2:1])
                    2'd0:    hdr_q.src_port <= {hdr_q.src_port[7:0], s_axis_tdata};
                    2'd1:    hdr_q.dst_port <= {hdr_q.dst_port[7:0], s_axis_tdata};
                    2'd2:    hdr_q.length   <= {hdr_q.length[7:0], s_axis_tdata};
                    default: hdr_q.checksum <= {hdr_q.checksum[7:0], s_axis_tdata};
                endcase
            end

            if (hdr_done) begin
                hdr_vld_q <= 1'b1;
                zero_pl_q <= s_axis_tlast;
            end else if (hdr_take) begin
                hdr_vld_q <= 1'b0;
            end

            if (hdr_take) begin
                pl_cnt_q  <= '0;
                last_in_q <= 1'b0;
            end else if ((state_q == PAYLOAD) && in_acc) begin
                if (pl_cnt_q != 16'hFFFF) begin
                    pl_cnt_q <= pl_cnt_q + 16'd1;
                end
                if (s_axis_tlast) begin
                    last_in_q <= 1'b1;
                end
            end else if (pl_drain) begin
                last_in_q <= 1'b0;
            end
        end
    end

    axis_pipe_reg #(
        .W(8)
    ) u_pl_pipe (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .s_dat   (s_axis_tdata),
        .s_vld   (pipe_s_vld),
        .s_lst   (s_axis_tlast),
        .s_rdy   (pipe_s_rdy),
        .m_dat   (m_axis_tdata),
        .m_vld   (m_axis_tvalid),
        .m_lst   (m_axis_tlast),
        .m_rdy   (m_axis_trdy)
    );

    assign m_udp_hdr_tvalid = hdr_vld_q;
    assign m_udp_src_port   = hdr_q.src_port;
    assign m_udp_dst_port   = hdr_q.dst_port;
    assign m_udp_length     = hdr_q.length;
    assign m_udp_checksum   = hdr_q.checksum;
    assign o_hdr_err        = hdr_err_q;
    assign o_len_err        = len_err_q;

endmodule

// File: tb/tb_udp_rx.sv
// Directed bench for udp_rx: scoreboard queues filled at stimulus time, popped by an output monitor.
module tb_udp_rx;

    logic        i_clk;
    logic        i_reset;
    logic [7:0]  s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_trdy;
    logic        m_udp_hdr_tvalid;
    logic        m_udp_hdr_trdy;
    logic [15:0] m_udp_src_port;
    logic [15:0] m_udp_dst_port;
    logic [15:0] m_udp_length;
    logic [15:0] m_udp_checksum;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_trdy = 1'b1;
    logic        o_hdr_err;
    logic        o_len_err;

    int checks = 0;
    int errors = 0;
    int exp_hdr_err = 0;
    int exp_len_err = 0;
    int hdr_err_seen = 0;
    int len_err_seen = 0;
    logic sb_en = 1'b0;
    logic rand_rdy = 1'b0;
    logic prev_stall = 1'b0;
    logic [8:0] prev_beat = '0;

    logic [63:0] exp_hdr_q[$];
    logic [8:0]  exp_pl_q[$];
    logic [7:0]  frm[$];

    udp_rx #(
        .AXI_DATA_WIDTH(8)
    ) dut (
        .i_clk            (i_clk),
        .i_reset          (i_reset),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tlast     (s_axis_tlast),
        .s_axis_trdy      (s_axis_trdy),
        .m_udp_hdr_tvalid (m_udp_hdr_tvalid),
        .m_udp_hdr_trdy   (m_udp_hdr_trdy),
        .m_udp_src_port   (m_udp_src_port),
        .m_udp_dst_port   (m_udp_dst_port),
        .m_udp_length     (m_udp_length),
        .m_udp_checksum   (m_udp_checksum),
        .m_axis_tdata     (m_axis_tdata),
        .m_axis_tvalid    (m_axis_tvalid),
        .m_axis_tlast     (m_axis_tlast),
        .m_axis_trdy      (m_axis_trdy),
        .o_hdr_err        (o_hdr_err),
        .o_len_err        (o_len_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(posedge i_clk) begin
        #1;
        m_axis_trdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Output monitor: samples on the falling edge, where a valid&&ready pair predicts the next transfer.
    always @(negedge i_clk) begin
        if (sb_en && !i_reset) begin
            if (m_udp_hdr_tvalid && m_udp_hdr_trdy) begin
                check("hdr_expected", 64'(exp_hdr_q.size() != 0), 64'd1);
                if (exp_hdr_q.size() != 0)
                    check("hdr_fields", {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum},
                          exp_hdr_q.pop_front());
            end
            if (prev_stall) begin
                check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, prev_beat});
            end
            if (m_axis_tvalid && m_axis_trdy) begin
                check("pl_expected", 64'(exp_pl_q.size() != 0), 64'd1);
                if (exp_pl_q.size() != 0)
                    check("pl_beat", {m_axis_tlast, m_axis_tdata}, exp_pl_q.pop_front());
            end
            prev_stall = m_axis_tvalid && !m_axis_trdy;
            prev_beat  = {m_axis_tlast, m_axis_tdata};
            if (o_hdr_err) hdr_err_seen++;
            if (o_len_err) len_err_seen++;
            if (o_hdr_err || o_len_err) check("err_exclusive", {o_hdr_err, o_len_err} == 2'b11, 64'd0);
        end else begin
            prev_stall = 1'b0;
        end
    end

    task automatic build_frame(input logic [15:0] src, input logic [15:0] dst, input logic [15:0] len,
                               input logic [15:0] csum, input int npl, input int rnd);
        frm = '{};
        frm.push_back(src[15:8]);  frm.push_back(src[7:0]);
        frm.push_back(dst[15:8]);  frm.push_back(dst[7:0]);
        frm.push_back(len[15:8]);  frm.push_back(len[7:0]);
        frm.push_back(csum[15:8]); frm.push_back(csum[7:0]);
        for (int k = 0; k < npl; k++) frm.push_back(rnd != 0 ? 8'($urandom) : 8'(k + 1));
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        int n;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        n = 0;
        @(negedge i_clk);
        while (!s_axis_trdy && n < 200) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        assert (n < 200) else begin
            errors++;
            $error("FAIL in_accept_timeout: waited %0d cycles, limit 200", n);
        end
        @(posedge i_clk);
        #1;
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic send_frame();
        int n;
        logic [15:0] len;
        n = frm.size();
        if (n >= 8) begin
            exp_hdr_q.push_back({frm[0], frm[1], frm[2], frm[3], frm[4], frm[5], frm[6], frm[7]});
            len = {frm[4], frm[5]};
            if (16'(n - 8) != len - 16'd8) exp_len_err++;
            for (int i = 8; i < n; i++) exp_pl_q.push_back({i == n - 1, frm[i]});
        end else begin
            exp_hdr_err++;
        end
        for (int i = 0; i < n; i++) send_byte(frm[i], i == n - 1);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((exp_hdr_q.size() != 0 || exp_pl_q.size() != 0) && n < 2000) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        assert (n < 2000) else begin
            errors++;
            $error("FAIL %s_drain: %0d hdr / %0d beats still pending, expected 0", tag,
                   exp_hdr_q.size(), exp_pl_q.size());
        end
        repeat (4) @(negedge i_clk);
        check({tag, "_hdr_err_cnt"}, 64'(hdr_err_seen), 64'(exp_hdr_err));
        check({tag, "_len_err_cnt"}, 64'(len_err_seen), 64'(exp_len_err));
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        i_reset        = 1'b0;
        s_axis_tdata   = '0;
        s_axis_tvalid  = 1'b0;
        s_axis_tlast   = 1'b0;
        m_udp_hdr_trdy = 1'b1;
        #1 i_reset = 1'b1;
        #1;
        check("reset_ctrl", {s_axis_trdy, m_udp_hdr_tvalid, m_axis_tvalid, m_axis_tlast, o_hdr_err, o_len_err}, 0);
        check("reset_fields", {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum}, 0);
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        sb_en = 1'b1;
        @(negedge i_clk);
        check("idle_trdy", s_axis_trdy, 1'b1);
        @(posedge i_clk);
        #1;

        // Basic frame, everything ready.
        build_frame(16'h1234, 16'h5678, 16'h000C, 16'hABCD, 4, 0);
        send_frame();
        wait_idle("t1");

        // Header consumer stalls for 5 cycles.
        m_udp_hdr_trdy = 1'b0;
        build_frame(16'h1234, 16'h5678, 16'h000C, 16'hABCD, 4, 0);
        fork
            send_frame();
            begin
                int n;
                n = 0;
                while (!m_udp_hdr_tvalid && n < 100) begin
                    @(negedge i_clk);
                    n++;
                end
                check("t2_hdr_seen", 64'(m_udp_hdr_tvalid), 64'd1);
                repeat (5) begin
                    @(negedge i_clk);
                    check("t2_trdy_low", s_axis_trdy, 1'b0);
                    check("t2_fields", {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum},
                          64'h1234_5678_000C_ABCD);
                end
                @(posedge i_clk);
                #1 m_udp_hdr_trdy = 1'b1;
            end
        join
        wait_idle("t2");

        // Random payload backpressure on a 64-byte payload.
        rand_rdy = 1'b1;
        build_frame(16'hC001, 16'h0035, 16'h0048, 16'h1111, 64, 1);
        send_frame();
        wait_idle("t3");
        rand_rdy = 1'b0;
        @(posedge i_clk);
        #2;

        // Truncated header, then a good frame.
        frm = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        send_frame();
        build_frame(16'h0BAD, 16'hBEEF, 16'h000A, 16'h0000, 2, 1);
        send_frame();
        wait_idle("t4");

        // Short payload, zero payload with matching length, zero payload with wrong length.
        build_frame(16'h0001, 16'h0002, 16'h0010, 16'h0003, 4, 0);
        send_frame();
        wait_idle("t5a");
        build_frame(16'h0004, 16'h0005, 16'h0008, 16'h0006, 0, 0);
        send_frame();
        wait_idle("t5b");
        build_frame(16'h0007, 16'h0008, 16'h000C, 16'h0009, 0, 0);
        send_frame();
        wait_idle("t5c");

        // Reset while payload byte 2 is being offered.
        sb_en = 1'b0;
        build_frame(16'h1234, 16'h5678, 16'h000C, 16'hABCD, 4, 0);
        for (int i = 0; i < 10; i++) send_byte(frm[i], 1'b0);
        s_axis_tdata  = frm[10];
        s_axis_tvalid = 1'b1;
        #2 i_reset = 1'b1;
        #1;
        check("t6_rst_ctrl", {s_axis_trdy, m_udp_hdr_tvalid, m_axis_tvalid, m_axis_tlast, o_hdr_err, o_len_err}, 0);
        check("t6_rst_data", m_axis_tdata, 0);
        check("t6_rst_fields", {m_udp_src_port, m_udp_dst_port, m_udp_length, m_udp_checksum}, 0);
        s_axis_tvalid = 1'b0;
        repeat (2) @(posedge i_clk);
        #1 i_reset = 1'b0;
        sb_en = 1'b1;
        build_frame(16'h1234, 16'h5678, 16'h000C, 16'hABCD, 4, 0);
        send_frame();
        wait_idle("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
